// File: rtl/sound_tone_sequencer_if.sv
// Game-logic side bundle for sound_tone_sequencer: sound requests and mute in,
// ack/busy/active_id status and the square-wave tone out.
interface sound_tone_sequencer_if;
  logic [3:0] req;
  logic       mute;
  logic [3:0] ack;
  logic       busy;
  logic [1:0] active_id;
  logic       tone_out;

  modport master (
    output req, mute,
    input  ack, busy, active_id, tone_out
  );

  modport slave (
    input  req, mute,
    output ack, busy, active_id, tone_out
  );
endinterface

// File: rtl/sound_tone_sequencer.sv
// Four-request fixed-priority tone sequencer driving a square-wave output.
// Define SND_PREEMPT_EN to let a higher pending sound abort the tone in PLAY.
module sound_tone_sequencer #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HALF_PER_0 = 113636,
  parameter int unsigned HALF_PER_1 = 56818,
  parameter int unsigned HALF_PER_2 = 28409,
  parameter int unsigned HALF_PER_3 = 14204,
  parameter int unsigned DUR_0      = 200,
  parameter int unsigned DUR_1      = 200,
  parameter int unsigned DUR_2      = 200,
  parameter int unsigned DUR_3      = 200,
  parameter int unsigned GAP_TICKS  = 20
) (
  input  logic                   ref_clk,
  input  logic                   reset,
  sound_tone_sequencer_if.slave  snd
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_RLD = PW'(TICK_DIV - 1);
  localparam logic [11:0]   GAP_RLD   = 12'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_e;

  function automatic logic [19:0] half_reload(input logic [1:0] id);
    int unsigned hp;
    case (id)
      2'd0:    hp = HALF_PER_0;
      2'd1:    hp = HALF_PER_1;
      2'd2:    hp = HALF_PER_2;
      default: hp = HALF_PER_3;
    endcase
    if (hp == 0) hp = 1;
    return 20'(hp - 1);
  endfunction

  function automatic logic [11:0] dur_of(input logic [1:0] id);
    case (id)
      2'd0:    return 12'(DUR_0);
      2'd1:    return 12'(DUR_1);
      2'd2:    return 12'(DUR_2);
      default: return 12'(DUR_3);
    endcase
  endfunction

  function automatic logic [1:0] top_idx(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    id_q, id_d;
  logic [3:0]    ack_q, ack_d;
  logic          busy_q;
  logic          tone_q, tone_d;
  logic          tone_out_q;
  logic [19:0]   half_q, half_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   cnt_q, cnt_d;
  logic          tick;
`ifdef SND_PREEMPT_EN
  logic [3:0]    above;
`endif

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      id_q       <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      tone_q     <= 1'b0;
      tone_out_q <= 1'b0;
      half_q     <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
      busy_q     <= (state_d != S_IDLE);
      tone_q     <= tone_d;
      tone_out_q <= tone_d & ~snd.mute;
      half_q     <= half_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
    end
  end

  // cnt_q holds remaining duration ticks in PLAY and remaining gap ticks in GAP.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    id_d      = id_q;
    ack_d     = '0;
    tone_d    = tone_q;
    half_d    = half_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    tick      = (presc_q == '0);
`ifdef SND_PREEMPT_EN
    above     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d                  = S_LOAD;
          id_d                     = top_idx(pending_q);
          ack_d[top_idx(pending_q)] = 1'b1;
        end
      end

      S_LOAD: begin
        pending_d[id_q] = 1'b0;
        half_d          = half_reload(id_q);
        presc_d         = PRESC_RLD;
        tone_d          = 1'b0;
        if (dur_of(id_q) == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_RLD;
        end else begin
          state_d = S_PLAY;
          cnt_d   = dur_of(id_q);
        end
      end

      S_PLAY: begin
        if (half_q == '0) begin
          tone_d = ~tone_q;
          half_d = half_reload(id_q);
        end else begin
          half_d = half_q - 20'd1;
        end
        if (tick) begin
          presc_d = PRESC_RLD;
          cnt_d   = cnt_q - 12'd1;
        end else begin
          presc_d = presc_q - PW'(1);
        end
        if (tick && cnt_q == 12'd1) begin
          state_d = S_GAP;
          tone_d  = 1'b0;
          cnt_d   = GAP_RLD;
          presc_d = PRESC_RLD;
        end
`ifdef SND_PREEMPT_EN
        // Preemption overrides a same-cycle PLAY->GAP transition.
        above = pending_q & (4'b1110 << id_q);
        if (above != '0) begin
          state_d               = S_LOAD;
          id_d                  = top_idx(above);
          ack_d[top_idx(above)] = 1'b1;
          tone_d                = 1'b0;
        end
`endif
      end

      S_GAP: begin
        tone_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          id_d    = '0;
        end else if (tick) begin
          presc_d = PRESC_RLD;
          cnt_d   = cnt_q - 12'd1;
          if (cnt_q == 12'd1) begin
            state_d = S_IDLE;
            id_d    = '0;
          end
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        id_d    = '0;
        tone_d  = 1'b0;
      end
    endcase

    // A request arriving in the serving LOAD cycle re-queues the sound.
    pending_d = pending_d | snd.req;
  end

  assign snd.ack       = ack_q;
  assign snd.busy      = busy_q;
  assign snd.active_id = id_q;
  assign snd.tone_out  = tone_out_q;

endmodule

// File: tb/tb_sound_tone_sequencer.sv
// Bench for sound_tone_sequencer: directed scenarios plus random requests, compared
// each cycle against a phase/time reference model of the sequencing rules.
module tb_sound_tone_sequencer;

  localparam int unsigned TICK = 10;
  localparam int unsigned HP  [4] = '{3, 5, 0, 2};
  localparam int unsigned DUR [4] = '{2, 0, 1, 1};
  localparam int unsigned GAP = 1;
`ifdef SND_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mute_v;

  sound_tone_sequencer_if snd();

  sound_tone_sequencer #(
    .TICK_DIV   (TICK),
    .HALF_PER_0 (HP[0]),
    .HALF_PER_1 (HP[1]),
    .HALF_PER_2 (HP[2]),
    .HALF_PER_3 (HP[3]),
    .DUR_0      (DUR[0]),
    .DUR_1      (DUR[1]),
    .DUR_2      (DUR[2]),
    .DUR_3      (DUR[3]),
    .GAP_TICKS  (GAP)
  ) dut (
    .ref_clk (clk),
    .reset   (rst),
    .snd     (snd)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase (0 idle, 1 load, 2 play, 3 gap) plus cycles spent in it.
  int unsigned m_phase, m_id, m_t;
  logic [3:0]  m_pend, m_ack;
  logic        m_tone;

  function automatic int unsigned half_of(input int unsigned id);
    return (HP[id] == 0) ? 1 : HP[id];
  endfunction

  function automatic int unsigned top(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_id = 0; m_t = 0;
    m_pend = '0; m_ack = '0; m_tone = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic m);
    int unsigned nphase, nid, nt, gap_len;
    logic [3:0] above;
    nphase  = m_phase;
    nid     = m_id;
    nt      = m_t + 1;
    gap_len = (GAP * TICK == 0) ? 1 : GAP * TICK;
    m_ack   = '0;
    case (m_phase)
      0: if (m_pend != '0) begin
           nphase = 1; nid = top(m_pend); m_ack[nid] = 1'b1; nt = 0;
         end
      1: begin
           m_pend[m_id] = 1'b0;
           nt = 0;
           nphase = (DUR[m_id] == 0) ? 3 : 2;
         end
      2: begin
           above = '0;
           for (int i = m_id + 1; i < 4; i++) above[i] = m_pend[i];
           if (PREEMPT && above != '0) begin
             nphase = 1; nid = top(above); m_ack[nid] = 1'b1; nt = 0;
           end else if (nt == DUR[m_id] * TICK) begin
             nphase = 3; nt = 0;
           end
         end
      default: if (nt >= gap_len) begin
           nphase = 0; nid = 0; nt = 0;
         end
    endcase
    m_pend  = m_pend | r;
    m_phase = nphase;
    m_id    = nid;
    m_t     = nt;
    m_tone  = (m_phase == 2) ? ((((m_t / half_of(m_id)) % 2) == 1) && !m) : 1'b0;
  endtask

  task automatic cycle(input logic [3:0] r, input logic m);
    snd.req  = r;
    snd.mute = m;
    model_step(r, m);
    @(posedge clk);
    @(negedge clk);
    check("ack",       snd.ack,       m_ack);
    check("busy",      snd.busy,      m_phase != 0);
    check("active_id", snd.active_id, m_id);
    check("tone_out",  snd.tone_out,  m_tone);
  endtask

  task automatic idle(input int unsigned n, input logic m);
    for (int i = 0; i < n; i++) cycle(4'b0000, m);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    snd.req = '0;
    #1;
    check("rst_ack",      snd.ack,       4'b0000);
    check("rst_busy",     snd.busy,      1'b0);
    check("rst_active",   snd.active_id, 2'd0);
    check("rst_tone_out", snd.tone_out,  1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    rst      = 1'b1;
    snd.req  = '0;
    snd.mute = 1'b0;
    mute_v   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("init_ack",  snd.ack,      4'b0000);
    check("init_busy", snd.busy,     1'b0);
    check("init_tone", snd.tone_out, 1'b0);
    rst = 1'b0;

    idle(3, 1'b0);
    do_reset();
    cycle(4'b0001, 1'b0); idle(40, 1'b0);
    cycle(4'b1010, 1'b0); idle(60, 1'b0);
    cycle(4'b0001, 1'b1); idle(40, 1'b1); idle(3, 1'b0);
    cycle(4'b0001, 1'b0); idle(7, 1'b0); cycle(4'b1000, 1'b0); idle(60, 1'b0);
    cycle(4'b0001, 1'b0); idle(10, 1'b0); cycle(4'b0001, 1'b0); idle(80, 1'b0);
    cycle(4'b0100, 1'b0); cycle(4'b0010, 1'b0); idle(40, 1'b0);
    cycle(4'b0001, 1'b0); idle(10, 1'b0); cycle(4'b0100, 1'b0); idle(2, 1'b0);
    do_reset();
    idle(40, 1'b0);

    for (int n = 0; n < 4000; n++) begin
      r = '0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 59) == 0) r[b] = 1'b1;
      if ($urandom_range(0, 99) == 0) mute_v = ~mute_v;
      if ($urandom_range(0, 1499) == 0) do_reset();
      cycle(r, mute_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
